// File: rtl/chip8_fb_pkg.sv
// Shared constants, FSM state encoding and address/pixel helpers for the
// CHIP-8 framebuffer.
package chip8_fb_pkg;

  localparam int unsigned FB_COLS      = 64;
  localparam int unsigned FB_ROWS      = 32;
  localparam int unsigned FB_BYTES     = 256;
  localparam int unsigned FB_ADDR_W    = 8;
  localparam int unsigned OLED_PAGES   = 8;
  localparam int unsigned OLED_LATENCY = 6;

  typedef enum logic [3:0] {
    IDLE,
    OLED_RD0,
    OLED_RD1,
    OLED_RD2,
    OLED_RD3,
    OLED_LAST,
    CPU_RD,
    CPU_RD_WAIT,
    CPU_XOR,
    CPU_DONE,
    CLEAR
  } fb_state_t;

  // Byte holding CHIP-8 row (page*4 + j) at byte column x_byte
  function automatic logic [FB_ADDR_W-1:0] oled_addr(input logic [2:0] page,
                                                     input logic [1:0] j,
                                                     input logic [2:0] x_byte);
    return {page, j, x_byte};
  endfunction

  // MSB of a byte is the leftmost pixel
  function automatic logic pixel_of(input logic [7:0] b, input logic [2:0] x_bit);
    return b[3'd7 - x_bit];
  endfunction

endpackage

// File: rtl/fb_ram.sv
// 256x8 single-port RAM with registered read, written so that tools infer a
// block RAM. Read-first: rdata returns the old byte on a write cycle.
module fb_ram
  import chip8_fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [FB_ADDR_W-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem [FB_BYTES];

  // Single shared port: optional write plus registered read of the same address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/chip8_framebuffer.sv
// CHIP-8 64x32 display memory serving OLED page/column reads (2x2 pixel
// scaling) and CPU read / XOR-draw with collision detection. All RAM traffic
// is serialised by one FSM.
// Optional macro FB_CLEAR_EN: clear sweep on reset exit and on cpu_clear.
module chip8_framebuffer
  import chip8_fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_collision,
  output logic       cpu_ack,
  input  logic       read,
  input  logic [5:0] row_idx,
  input  logic [6:0] column_idx,
  output logic [7:0] data,
  output logic       ack,
  input  logic       cpu_clear,
  output logic       busy
);

  fb_state_t state_q, state_d;

  logic [2:0]           page_q, pend_page_q;
  logic [5:0]           x_q, pend_x_q;
  logic                 pend_q;
  logic [FB_ADDR_W-1:0] cpu_addr_q;
  logic [7:0]           cpu_wdata_q;
  logic                 cpu_we_q;
  logic [2:0]           pix_q;
  logic [7:0]           data_q;
  logic                 ack_q;
  logic [7:0]           cpu_rdata_q;
  logic                 cpu_coll_q;
  logic [7:0]           clear_cnt_q;
  logic                 clear_go;

  logic                 ram_we;
  logic [FB_ADDR_W-1:0] ram_addr;
  logic [7:0]           ram_wdata, ram_rdata;

  logic [3:0]           unused_bits;
  assign unused_bits = {row_idx[5:3], column_idx[0]};

`ifdef FB_CLEAR_EN
  logic clear_pend_q;
  assign clear_go = clear_pend_q | cpu_clear;
  assign busy     = (state_q == CLEAR);
`else
  logic unused_clear;
  assign unused_clear = cpu_clear;
  assign clear_go     = 1'b0;
  assign busy         = 1'b0;
`endif

  assign data = data_q;
  assign ack  = ack_q;

  fb_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: in IDLE an OLED read (pending or new) beats clear, which beats the CPU
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pend_q || read)  state_d = OLED_RD0;
        else if (clear_go)   state_d = CLEAR;
        else if (cpu_req)    state_d = CPU_RD;
      end
      OLED_RD0:    state_d = OLED_RD1;
      OLED_RD1:    state_d = OLED_RD2;
      OLED_RD2:    state_d = OLED_RD3;
      OLED_RD3:    state_d = OLED_LAST;
      OLED_LAST:   state_d = IDLE;
      CPU_RD:      state_d = cpu_we_q ? CPU_XOR : CPU_RD_WAIT;
      CPU_RD_WAIT: state_d = IDLE;
      CPU_XOR:     state_d = CPU_DONE;
      CPU_DONE:    state_d = IDLE;
      CLEAR:       if (clear_cnt_q == 8'hFF) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // RAM port steering and CPU handshake outputs decoded from the current state
  always_comb begin
    ram_we        = 1'b0;
    ram_addr      = cpu_addr_q;
    ram_wdata     = '0;
    cpu_ack       = 1'b0;
    cpu_rdata     = cpu_rdata_q;
    cpu_collision = cpu_coll_q;
    case (state_q)
      OLED_RD0: ram_addr = oled_addr(page_q, 2'd0, x_q[5:3]);
      OLED_RD1: ram_addr = oled_addr(page_q, 2'd1, x_q[5:3]);
      OLED_RD2: ram_addr = oled_addr(page_q, 2'd2, x_q[5:3]);
      OLED_RD3: ram_addr = oled_addr(page_q, 2'd3, x_q[5:3]);
      CPU_RD_WAIT: begin
        cpu_ack       = 1'b1;
        cpu_rdata     = ram_rdata;
        cpu_collision = 1'b0;
      end
      CPU_XOR: begin
        ram_we    = 1'b1;
        ram_wdata = ram_rdata ^ cpu_wdata_q;
      end
      CPU_DONE: cpu_ack = 1'b1;
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clear_cnt_q;
        ram_wdata = '0;
      end
      default: ;
    endcase
  end

  // Request capture, pending read/clear, pixel gathering and held results
  always_ff @(posedge clk) begin
    if (reset) begin
      page_q      <= '0;
      x_q         <= '0;
      pend_q      <= 1'b0;
      pend_page_q <= '0;
      pend_x_q    <= '0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_we_q    <= 1'b0;
      pix_q       <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_coll_q  <= 1'b0;
      clear_cnt_q <= '0;
`ifdef FB_CLEAR_EN
      clear_pend_q <= 1'b1;
`endif
    end else begin
      ack_q <= 1'b0;
      if (state_q != IDLE && read && !pend_q) begin
        pend_q      <= 1'b1;
        pend_page_q <= row_idx[2:0];
        pend_x_q    <= column_idx[6:1];
      end
`ifdef FB_CLEAR_EN
      if (cpu_clear) clear_pend_q <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            page_q <= pend_page_q;
            x_q    <= pend_x_q;
            pend_q <= 1'b0;
          end else if (read) begin
            page_q <= row_idx[2:0];
            x_q    <= column_idx[6:1];
          end else if (clear_go) begin
`ifdef FB_CLEAR_EN
            clear_pend_q <= 1'b0;
`endif
            clear_cnt_q <= '0;
          end else if (cpu_req) begin
            cpu_addr_q  <= cpu_addr;
            cpu_wdata_q <= cpu_wdata;
            cpu_we_q    <= cpu_we;
          end
        end
        OLED_RD1: pix_q[0] <= pixel_of(ram_rdata, x_q[2:0]);
        OLED_RD2: pix_q[1] <= pixel_of(ram_rdata, x_q[2:0]);
        OLED_RD3: pix_q[2] <= pixel_of(ram_rdata, x_q[2:0]);
        OLED_LAST: begin
          data_q <= {{2{pixel_of(ram_rdata, x_q[2:0])}},
                     {2{pix_q[2]}}, {2{pix_q[1]}}, {2{pix_q[0]}}};
          ack_q  <= 1'b1;
        end
        CPU_RD_WAIT: begin
          cpu_rdata_q <= ram_rdata;
          cpu_coll_q  <= 1'b0;
        end
        CPU_XOR: begin
          cpu_rdata_q <= ram_rdata;
          cpu_coll_q  <= |(ram_rdata & cpu_wdata_q);
        end
        CLEAR: clear_cnt_q <= clear_cnt_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Self-checking bench for chip8_framebuffer: directed scenarios plus random
// CPU/OLED traffic checked against a pixel-array reference model.
module tb_chip8_framebuffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_collision, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       read, ack, cpu_clear, busy;
  logic [5:0] row_idx;
  logic [6:0] column_idx;
  logic [7:0] data;

  int checks;
  int errors;
  logic [7:0] model [256];

  chip8_framebuffer dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_collision (cpu_collision),
    .cpu_ack       (cpu_ack),
    .read          (read),
    .row_idx       (row_idx),
    .column_idx    (column_idx),
    .data          (data),
    .ack           (ack),
    .cpu_clear     (cpu_clear),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // OLED page byte from the pixel grid: 2x2 scaling, bit0 = top pixel
  function automatic logic [7:0] oled_expect(input int page, input int col);
    int x, row;
    logic [7:0] b, r;
    x = col / 2;
    r = 8'h00;
    for (int j = 0; j < 4; j++) begin
      row = page * 4 + j;
      b = model[row * 8 + x / 8];
      if (b[7 - (x % 8)]) r = r | (8'h03 << (2 * j));
    end
    return r;
  endfunction

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] w,
                        output logic [7:0] r, output logic c, output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = w;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!cpu_ack && lat < 1000);
    r = cpu_rdata; c = cpu_collision;
    cpu_req = 1'b0;
    if (!cpu_ack) checkOutput("cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic oled_read(input logic [5:0] row, input logic [6:0] col,
                           output logic [7:0] d, output int lat);
    @(negedge clk);
    read = 1'b1; row_idx = row; column_idx = col;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk); read = 1'b0;
    end while (!ack && lat < 1000);
    d = data;
    if (!ack) checkOutput("oled_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic xor_write(input string tag, input logic [7:0] a, input logic [7:0] w);
    logic [7:0] r; logic c; int lat; logic [7:0] old;
    old = model[a];
    cpu_op(1'b1, a, w, r, c, lat);
    checkOutput({tag, "_lat"}, lat, 3);
    checkOutput({tag, "_rdata"}, r, old);
    checkOutput({tag, "_coll"}, c, |(old & w));
    model[a] = old ^ w;
  endtask

  task automatic oled_check(input string tag, input logic [5:0] row, input logic [6:0] col,
                            input logic [7:0] exp);
    logic [7:0] d; int lat;
    oled_read(row, col, d, lat);
    checkOutput({tag, "_lat"}, lat, 6);
    checkOutput({tag, "_data"}, d, exp);
  endtask

  task automatic applyStimulus(input int n);
    logic [7:0] a, w, r, d; logic c; int lat; logic [5:0] row; logic [6:0] col;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      w = 8'($urandom);
      case ($urandom_range(0, 2))
        0: xor_write("rnd_xor", a, w);
        1: begin
          cpu_op(1'b0, a, 8'h00, r, c, lat);
          checkOutput("rnd_rd_lat", lat, 2);
          checkOutput("rnd_rd_data", r, model[a]);
        end
        default: begin
          row = 6'($urandom);
          if ($urandom_range(0, 1) == 1) row[2:0] = 3'd0;
          col = 7'($urandom);
          oled_read(row, col, d, lat);
          checkOutput("rnd_oled_lat", lat, 6);
          checkOutput("rnd_oled_data", d, oled_expect(int'(row[2:0]), int'(col)));
        end
      endcase
    end
  endtask

  initial begin
    logic [7:0] r, d;
    logic c, busy_at_ack;
    int lat, cnt, ack_at, cack_at, last_busy;

    checks = 0; errors = 0;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    read = 1'b0; row_idx = '0; column_idx = '0; cpu_clear = 1'b0;
    for (int a = 0; a < 256; a++) model[a] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_cpu_ack", cpu_ack, 0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 0);
    checkOutput("reset_cpu_coll", cpu_collision, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;

`ifdef FB_CLEAR_EN
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    checkOutput("reset_sweep_busy_cycles", cnt, 256);
`else
    for (int a = 0; a < 256; a++) begin
      cpu_op(1'b0, 8'(a), 8'h00, r, c, lat);
      if (r != 8'h00) cpu_op(1'b1, 8'(a), r, r, c, lat);
    end
`endif

    $display("[TB] directed scenarios");
    oled_check("first_read", 6'd0, 7'd0, 8'h00);
    xor_write("xor0", 8'h00, 8'h80);
    oled_check("p0c0", 6'd0, 7'd0, 8'h03);
    @(negedge clk);
    checkOutput("data_hold", data, 8'h03);
    checkOutput("ack_pulse", ack, 0);
    oled_check("p0c1", 6'd0, 7'd1, 8'h03);
    oled_check("p0c2", 6'd0, 7'd2, 8'h00);
    xor_write("xor0_again", 8'h00, 8'h80);
    checkOutput("xor0_again_coll_set", cpu_collision, 1);
    cpu_op(1'b0, 8'h00, 8'h00, r, c, lat);
    checkOutput("rd0_lat", lat, 2);
    checkOutput("rd0_data", r, 8'h00);
    xor_write("xor1f", 8'h1F, 8'h01);
    oled_check("p0c127", 6'd0, 7'd127, 8'hC0);
    oled_check("p0c125", 6'd0, 7'd125, 8'h00);
    oled_check("p1c127", 6'd1, 7'd127, 8'h00);

    // OLED read and CPU read sampled together: OLED wins, CPU follows
    @(negedge clk);
    read = 1'b1; row_idx = 6'd0; column_idx = 7'd127;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h1F;
    ack_at = 0; cack_at = 0; d = 8'h00; r = 8'h00;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); @(negedge clk); read = 1'b0;
      if (ack && ack_at == 0) begin ack_at = cyc; d = data; end
      if (cpu_ack && cack_at == 0) begin cack_at = cyc; r = cpu_rdata; cpu_req = 1'b0; end
    end
    checkOutput("conc_ack_cycle", ack_at, 6);
    checkOutput("conc_oled_data", d, 8'hC0);
    checkOutput("conc_cpu_ack_cycle", cack_at, 8);
    checkOutput("conc_cpu_rdata", r, 8'h01);

    // OLED read arriving during an XOR write is pended
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h08; cpu_wdata = 8'h60;
    ack_at = 0; cack_at = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); @(negedge clk);
      read = (cyc == 1);
      if (cyc == 1) begin row_idx = 6'd8; column_idx = 7'd2; end
      if (cpu_ack && cack_at == 0) begin cack_at = cyc; cpu_req = 1'b0; end
      if (ack && ack_at == 0) begin ack_at = cyc; d = data; end
    end
    model[8'h08] = model[8'h08] ^ 8'h60;
    checkOutput("pend_cpu_ack_cycle", cack_at, 3);
    checkOutput("pend_ack_cycle", ack_at, 10);
    checkOutput("pend_oled_data", d, oled_expect(0, 2));

    $display("[TB] random traffic");
    applyStimulus(80);

`ifdef FB_CLEAR_EN
    for (int a = 0; a < 256; a++) begin
      cpu_op(1'b1, 8'(a), ~model[a], r, c, lat);
      model[a] = 8'hFF;
    end
    oled_check("full_p3c50", 6'd3, 7'd50, 8'hFF);
    @(negedge clk); cpu_clear = 1'b1;
    cnt = 0; last_busy = 0; ack_at = 0; busy_at_ack = 1'b1; d = 8'hAA;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); @(negedge clk);
      cpu_clear = 1'b0;
      read = (cyc == 100);
      if (cyc == 100) begin row_idx = 6'd2; column_idx = 7'd40; end
      if (busy) begin cnt++; last_busy = cyc; end
      if (ack && ack_at == 0) begin ack_at = cyc; d = data; busy_at_ack = busy; end
    end
    for (int a = 0; a < 256; a++) model[a] = 8'h00;
    checkOutput("clear_busy_cycles", cnt, 256);
    checkOutput("clear_ack_after_idle", ack_at - last_busy, 7);
    checkOutput("clear_busy_at_ack", busy_at_ack, 0);
    checkOutput("clear_oled_data", d, 8'h00);
    cpu_op(1'b0, 8'h9C, 8'h00, r, c, lat);
    checkOutput("clear_cpu_rdata", r, 8'h00);
`else
    @(negedge clk); cpu_clear = 1'b1;
    cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); @(negedge clk);
      cpu_clear = 1'b0;
      if (busy) cnt++;
    end
    checkOutput("noclear_busy_cycles", cnt, 0);
    cpu_op(1'b0, 8'h1F, 8'h00, r, c, lat);
    checkOutput("noclear_rdata", r, model[8'h1F]);
`endif

    // Reset during a CPU read aborts it without an ack
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h1F;
    @(posedge clk); @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 1) reset = 1'b0;
      if (cpu_ack) cnt++;
    end
    checkOutput("reset_abort_no_ack", cnt, 0);
`ifdef FB_CLEAR_EN
    for (int a = 0; a < 256; a++) model[a] = 8'h00;
`endif
    cpu_op(1'b0, 8'h1F, 8'h00, r, c, lat);
    checkOutput("post_reset_rdata", r, model[8'h1F]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_framebuffer.md
Name: chip8_framebuffer

Overview:
CHIP-8 display memory: 64x32 monochrome pixels stored as 256 bytes. It serves the OLED driver's page/column byte reads and replaces the test-pattern source on the read/ack interface. Each CHIP-8 pixel is scaled 2x2 onto the 128x64 panel. A second port lets the CPU read bytes and XOR-draw them with collision detection, as the DRW instruction requires.

Parameters:
FB_BYTES, 256, display memory depth (8 bytes per row x 32 rows)
OLED_LATENCY, 6, fixed clocks from an accepted read to ack (informational; not an override)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, level, sampled only in IDLE
cpu_we  in  1  1 = XOR-write, 0 = read
cpu_addr  in  8  byte address = row*8 + x/8; MSB of byte = leftmost pixel
cpu_wdata  in  8  sprite byte to XOR in
cpu_rdata  out  8  byte value before the access
cpu_collision  out  1  1 if any set bit of cpu_wdata hit a set pixel
cpu_ack  out  1  one-cycle pulse; cpu_rdata and cpu_collision valid in this cycle
read  in  1  OLED byte request, one-cycle pulse
row_idx  in  6  OLED page index; only [2:0] used
column_idx  in  7  OLED column 0..127
data  out  8  OLED page byte; bit0 = top pixel
ack  out  1  one-cycle pulse; data valid in this cycle and held until the next ack
cpu_clear  in  1  clear request pulse (functional only with FB_CLEAR_EN)
busy  out  1  clear sweep in progress

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, pending-read flag cleared. RAM contents are retained unless FB_CLEAR_EN is defined.
- Reset mid-operation: the operation is aborted and no ack is issued. An XOR write commits in a single cycle, so it is atomic.
- Memory: 256x8 single-port RAM with synchronous read (1-cycle latency). All RAM access is serialised by one FSM.
- Pending read: a read pulse that arrives while not in IDLE latches row_idx[2:0], column_idx and a pending flag. It is then served as if it had just been sampled in IDLE. A second read while pending is ignored.
- IDLE priority: OLED read (new or pending) > clear > cpu_req.
- OLED fetch mapping:
  - x = column_idx[6:1], page = row_idx[2:0].
  - For j = 0..3, address = {page, j[1:0], x[5:3]}; pixel = bit (7 - x[2:0]).
  - The pixel of row j drives data bits 2j and 2j+1.
- OLED timing:
  - Read sampled in IDLE at cycle T. States OLED_RD0..3 issue addresses at T+1..T+4; bytes are captured at T+2..T+5.
  - ack is high at T+6, with data registered. The FSM is in IDLE in the ack cycle, so a new request can be sampled then.
- CPU read: req sampled at T; RAM read issued at T+1; cpu_ack with cpu_rdata at T+2.
- CPU XOR write:
  - req sampled at T; read at T+1; at T+2 write old ^ wdata.
  - At T+3: cpu_ack, cpu_rdata = old, cpu_collision = |(old & wdata).
- Request handshake: the requester drops cpu_req in the cycle after cpu_ack. A req still high then starts a new transaction.
- Address range: all 256 cpu_addr values are valid; there is no wrap logic. row_idx[5:3] is ignored. Column 127 maps to x = 63.
- Outputs: cpu_rdata and cpu_collision hold between acks.

Optional Feature:
FB_CLEAR_EN
- Defined: a cpu_clear pulse (latched if the FSM is busy) and reset exit both start a sweep writing 0x00 to addresses 0..255, one per cycle. busy is high for exactly 256 cycles. OLED reads during the sweep are pended and served afterwards. cpu_req waits.
- Undefined: cpu_clear is ignored, busy is tied 0, and RAM is uninitialised after configuration.

Decomposition:
- Package chip8_fb_pkg:
  - constants FB_COLS=64, FB_ROWS=32, FB_BYTES=256, FB_ADDR_W=8, OLED_PAGES=8;
  - FSM state encoding: IDLE, OLED_RD0-3, OLED_LAST, CPU_RD, CPU_RD_WAIT, CPU_XOR, CPU_DONE, CLEAR.
- Sub-module fb_ram: 256x8 single-port synchronous RAM (we, addr, wdata, rdata), inferable as block RAM.

Test Plan:
- After reset, RAM preloaded with 0, read page 0 col 0 -> ack exactly 6 cycles later, data = 0x00.
- XOR-write addr 0x00 wdata 0x80 -> cpu_ack at +3, rdata 0x00, collision 0; OLED page 0 col 0 -> 0x03, col 1 -> 0x03, col 2 -> 0x00.
- Repeat the same XOR-write -> rdata 0x80, collision 1; subsequent CPU read of addr 0x00 -> 0x00.
- XOR-write addr 0x1F wdata 0x01 -> OLED page 0 col 127 = 0xC0, col 125 = 0x00, page 1 col 127 = 0x00.
- read and cpu_req (read addr 0x1F) in the same cycle T -> ack at T+6, then cpu_ack at T+8 with rdata 0x01; read pulsed during the CPU op -> pended and acked 6 cycles after the FSM returns to IDLE.
- FB_CLEAR_EN: fill RAM with 0xFF, pulse cpu_clear -> busy high for 256 cycles, and a read issued mid-sweep acks after busy falls with data 0x00. Without the macro: cpu_clear is ignored and busy stays 0.
